// File: rtl/tt_vpu_pkg.sv
// Shared VPU load-path types: LDB geometry, entry layout and drain FSM states.
package tt_vpu_pkg;

   localparam int unsigned LDB_DEPTH  = 8;
   localparam int unsigned LDB_IDX_W  = 3;
   localparam int unsigned LDB_DATA_W = 512;
   localparam int unsigned LDB_MASK_W = LDB_DATA_W / 8;

   typedef struct packed {
      logic [LDB_DATA_W-1:0] data;
      logic [LDB_MASK_W-1:0] mask;
   } ldb_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FILL,
      SEND
   } drain_state_e;

endpackage

// File: rtl/tt_ldb_storage.sv
// Load data buffer: data/mask array plus a filled vector. One fill port, one drain-clear port,
// one asynchronous read port.
module tt_ldb_storage
   import tt_vpu_pkg::*;
#(
   parameter int unsigned DATA_W = LDB_DATA_W,
   parameter int unsigned MASK_W = LDB_MASK_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_valid,
   input  logic [LDB_IDX_W-1:0] wr_idx,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [MASK_W-1:0]    wr_mask,
   input  logic                 clr_valid,
   input  logic [LDB_IDX_W-1:0] clr_idx,
   input  logic [LDB_IDX_W-1:0] rd_idx,
   output logic [DATA_W-1:0]    rd_data,
   output logic [MASK_W-1:0]    rd_mask,
   output logic [LDB_DEPTH-1:0] filled
);

   logic [DATA_W-1:0]    data_mem [LDB_DEPTH];
   logic [MASK_W-1:0]    mask_mem [LDB_DEPTH];
   logic [LDB_DEPTH-1:0] filled_q, filled_d;

   // Fill is applied after the clear so a same-index collision leaves the entry filled.
   always_comb begin
      filled_d = filled_q;
      if (clr_valid) filled_d[clr_idx] = 1'b0;
      if (wr_valid)  filled_d[wr_idx]  = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) filled_q <= '0;
      else          filled_q <= filled_d;
   end

   always_ff @(posedge clk) begin
      if (wr_valid) begin
         data_mem[wr_idx] <= wr_data;
         mask_mem[wr_idx] <= wr_mask;
      end
   end

   assign rd_data = data_mem[rd_idx];
   assign rd_mask = mask_mem[rd_idx];
   assign filled  = filled_q;

`ifndef SYNTHESIS
   fill_to_free_entry_a: assert property (@(posedge clk) disable iff (!reset_n)
      wr_valid |-> (!filled_q[wr_idx] || (clr_valid && clr_idx == wr_idx)))
      else $error("LDB fill to an occupied entry");
`endif

endmodule

// File: rtl/tt_ldb_drain_ctrl.sv
// Drain controller: accepts one scoreboard drain request and streams its LDB entries to the
// VPU writeback port. Define TT_LDB_FILL_BYPASS_EN to forward a matching fill straight into SEND.
module tt_ldb_drain_ctrl
   import tt_vpu_pkg::*;
#(
   parameter int unsigned DATA_W = LDB_DATA_W,
   parameter int unsigned MASK_W = LDB_MASK_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_drain_load_buffer,
   input  logic [LDB_IDX_W-1:0] i_drain_ref_count,
   input  logic [LDB_IDX_W-1:0] i_drain_lqid_start,
   input  logic [LDB_IDX_W-1:0] i_drain_ldb_start,
   output logic                 o_draining_load_buffer,
   output logic                 o_drain_complete_valid,
   output logic [LDB_IDX_W-1:0] o_drain_complete_ldb_idx,
   input  logic                 i_ldb_fill_valid,
   input  logic [LDB_IDX_W-1:0] i_ldb_fill_idx,
   input  logic [DATA_W-1:0]    i_ldb_fill_data,
   input  logic [MASK_W-1:0]    i_ldb_fill_mask,
   output logic                 o_wb_valid,
   input  logic                 i_wb_ready,
   output logic [DATA_W-1:0]    o_wb_data,
   output logic [MASK_W-1:0]    o_wb_mask,
   output logic [LDB_IDX_W-1:0] o_wb_lqid,
   output logic                 o_wb_last
);

   drain_state_e         state_q, state_d;
   logic [LDB_IDX_W-1:0] ptr_q, ptr_d;
   logic [LDB_IDX_W-1:0] lqid_q, lqid_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0]    wb_data_q, wb_data_d;
   logic [MASK_W-1:0]    wb_mask_q, wb_mask_d;
   logic                 cmpl_valid_q, cmpl_valid_d;
   logic [LDB_IDX_W-1:0] cmpl_idx_q, cmpl_idx_d;

   logic                 clr_valid;
   logic                 fill_hit;
   logic [DATA_W-1:0]    rd_data;
   logic [MASK_W-1:0]    rd_mask;
   logic [LDB_DEPTH-1:0] filled;

   tt_ldb_storage #(
      .DATA_W (DATA_W),
      .MASK_W (MASK_W)
   ) u_storage (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_valid  (i_ldb_fill_valid),
      .wr_idx    (i_ldb_fill_idx),
      .wr_data   (i_ldb_fill_data),
      .wr_mask   (i_ldb_fill_mask),
      .clr_valid (clr_valid),
      .clr_idx   (ptr_q),
      .rd_idx    (ptr_q),
      .rd_data   (rd_data),
      .rd_mask   (rd_mask),
      .filled    (filled)
   );

`ifdef TT_LDB_FILL_BYPASS_EN
   assign fill_hit = i_ldb_fill_valid && (i_ldb_fill_idx == ptr_q);
`else
   assign fill_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      lqid_d       = lqid_q;
      cnt_d        = cnt_q;
      wb_valid_d   = wb_valid_q;
      wb_data_d    = wb_data_q;
      wb_mask_d    = wb_mask_q;
      cmpl_valid_d = 1'b0;
      cmpl_idx_d   = cmpl_idx_q;
      clr_valid    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_drain_load_buffer) begin
               ptr_d   = i_drain_ldb_start;
               lqid_d  = i_drain_lqid_start;
               cnt_d   = (i_drain_ref_count == '0) ? 4'd8 : {1'b0, i_drain_ref_count};
               state_d = WAIT_FILL;
            end
         end
         WAIT_FILL: begin
            if (fill_hit || filled[ptr_q]) begin
               state_d    = SEND;
               wb_valid_d = 1'b1;
               wb_data_d  = fill_hit ? i_ldb_fill_data : rd_data;
               wb_mask_d  = fill_hit ? i_ldb_fill_mask : rd_mask;
            end
         end
         SEND: begin
            if (wb_valid_q && i_wb_ready) begin
               cmpl_valid_d = 1'b1;
               cmpl_idx_d   = ptr_q;
               clr_valid    = 1'b1;
               ptr_d        = ptr_q + 3'd1;
               lqid_d       = lqid_q + 3'd1;
               cnt_d        = cnt_q - 4'd1;
               wb_valid_d   = 1'b0;
               state_d      = (cnt_q == 4'd1) ? IDLE : WAIT_FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         lqid_q       <= '0;
         cnt_q        <= '0;
         wb_valid_q   <= 1'b0;
         wb_data_q    <= '0;
         wb_mask_q    <= '0;
         cmpl_valid_q <= 1'b0;
         cmpl_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         lqid_q       <= lqid_d;
         cnt_q        <= cnt_d;
         wb_valid_q   <= wb_valid_d;
         wb_data_q    <= wb_data_d;
         wb_mask_q    <= wb_mask_d;
         cmpl_valid_q <= cmpl_valid_d;
         cmpl_idx_q   <= cmpl_idx_d;
      end
   end

   assign o_draining_load_buffer   = (state_q != IDLE);
   assign o_drain_complete_valid   = cmpl_valid_q;
   assign o_drain_complete_ldb_idx = cmpl_idx_q;
   assign o_wb_valid               = wb_valid_q;
   assign o_wb_data                = wb_data_q;
   assign o_wb_mask                = wb_mask_q;
   assign o_wb_lqid                = lqid_q;
   assign o_wb_last                = (cnt_q == 4'd1);

endmodule
